// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with frame-boundary double buffering.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module digit_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned NUM_DIGITS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    upd,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [2:0]              digit_sel,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int unsigned     CntW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax    = CntW'(REFRESH_DIV - 1);
    localparam logic [2:0]      LastDigit = 3'(NUM_DIGITS - 1);
    localparam int unsigned     DataW     = 4 * NUM_DIGITS;

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2:0]            digit_q, digit_d;
    logic [DataW-1:0]      act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
    logic [DataW-1:0]      pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
    logic                  busy_q, busy_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick;
    logic                  wrap;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic                  zero_above;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h7F;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Prescaler, digit index and buffer handover.
    always_comb begin
        tick         = en && (cnt_q == CntMax);
        wrap         = tick && (digit_q == LastDigit);
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        busy_d       = busy_q;
        frame_done_d = wrap;

        if (tick) begin
            cnt_d   = '0;
            digit_d = wrap ? 3'd0 : digit_q + 3'd1;
        end else if (en) begin
            cnt_d = cnt_q + CntW'(1);
        end

        if (wrap) begin
            // A strobe coinciding with the boundary bypasses the pending buffer.
            if (upd) begin
                act_data_d  = data;
                act_dp_d    = dp_mask;
                act_blank_d = blank_mask;
            end else if (busy_q) begin
                act_data_d  = pend_data_q;
                act_dp_d    = pend_dp_q;
                act_blank_d = pend_blank_q;
            end
            busy_d = 1'b0;
        end else if (upd) begin
            pend_data_d  = data;
            pend_dp_d    = dp_mask;
            pend_blank_d = blank_mask;
            busy_d       = 1'b1;
        end
    end

    // Segment outputs track the next-state index and buffer so they switch with digit_sel.
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above & (act_data_d[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_above;
        end
`endif
        blank_vec = act_blank_d | lz_blank;

        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_d == 3'(i)) begin
                cur_nib   = act_data_d[4*i +: 4];
                cur_dp    = act_dp_d[i];
                cur_blank = blank_vec[i];
            end
        end

        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        if (en) begin
            seg_n_d = cur_blank ? 7'h7F : hex_to_seg(cur_nib);
            dp_n_d  = ~cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            digit_q      <= 3'd0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            busy_q       <= 1'b0;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            busy_q       <= busy_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_sel  = digit_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: stimulus pushes expected outputs, a monitor compares.
module tb_digit_scan_ctrl;

    localparam int unsigned DIV = 4;
    localparam int unsigned ND  = 8;

    typedef struct packed {
        logic [2:0] d;
        logic [6:0] s;
        logic       dp;
        logic       fd;
        logic       busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        upd = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  blank_mask = '0;
    logic [2:0]  digit_sel;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model state
    int          m_cnt, m_digit;
    logic [31:0] m_act_data, m_pend_data;
    logic [7:0]  m_act_dp, m_pend_dp, m_act_blank, m_pend_blank;
    bit          m_busy;
    logic [6:0]  hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    digit_scan_ctrl #(.REFRESH_DIV(DIV), .NUM_DIGITS(ND)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .upd        (upd),
        .data       (data),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .digit_sel  (digit_sel),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_digit = 0; m_busy = 0;
        m_act_data = '0; m_act_dp = '0; m_act_blank = '0;
        m_pend_data = '0; m_pend_dp = '0; m_pend_blank = '0;
    endtask

    // Advance the model over one rising edge using the inputs currently driven.
    task automatic model_step(output exp_t e);
        bit tick, wrap, blanked;
        int nib;
        if (!rst_n) begin
            model_reset();
            e.d = 3'd0; e.s = 7'h7F; e.dp = 1'b1; e.fd = 1'b0; e.busy = 1'b0;
        end else begin
            tick = en && (m_cnt == DIV - 1);
            wrap = tick && (m_digit == ND - 1);
            if (tick) begin
                m_cnt = 0;
                m_digit = (m_digit + 1) % ND;
            end else if (en) begin
                m_cnt++;
            end
            if (wrap) begin
                if (upd) begin
                    m_act_data = data; m_act_dp = dp_mask; m_act_blank = blank_mask;
                end else if (m_busy) begin
                    m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
                end
                m_busy = 0;
            end else if (upd) begin
                m_pend_data = data; m_pend_dp = dp_mask; m_pend_blank = blank_mask;
                m_busy = 1;
            end
            nib = int'((m_act_data >> (4 * m_digit)) & 32'hF);
            blanked = m_act_blank[m_digit];
`ifdef LEADING_ZERO_BLANK_EN
            if (m_digit != 0 && (m_act_data >> (4 * m_digit)) == 32'h0) blanked = 1;
`endif
            e.d    = 3'(m_digit);
            e.s    = !en ? 7'h7F : (blanked ? 7'h7F : hex_lut[nib]);
            e.dp   = !en ? 1'b1 : ~m_act_dp[m_digit];
            e.fd   = wrap;
            e.busy = m_busy;
        end
    endtask

    task automatic cyc(input bit e_en, input bit u, input logic [31:0] d,
                       input logic [7:0] dp, input logic [7:0] bl);
        exp_t ex;
        @(negedge clk);
        rst_n = 1'b1; en = e_en; upd = u; data = d; dp_mask = dp; blank_mask = bl;
        model_step(ex);
        exp_q.push_back(ex);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
    endtask

    task automatic reset_pulse(input bit check_now);
        exp_t ex;
        @(negedge clk);
        rst_n = 1'b0; upd = 1'b0;
        #1;
        if (check_now) begin
            chk("async_rst_digit_sel", 32'(digit_sel), 32'd0);
            chk("async_rst_seg_n", 32'(seg_n), 32'h7F);
            chk("async_rst_busy", 32'(busy), 32'd0);
        end
        model_step(ex);
        exp_q.push_back(ex);
    endtask

    // Idle until the model reaches the given slot (cnt<0 means any cnt), bounded.
    task automatic wait_slot(input int dig, input int cnt);
        for (int i = 0; i < 4 * DIV * ND; i++) begin
            if (m_digit == dig && (cnt < 0 || m_cnt == cnt)) break;
            idle(1);
        end
    endtask

    exp_t mon_ex;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_ex = exp_q.pop_front();
            chk("digit_sel", 32'(digit_sel), 32'(mon_ex.d));
            chk("seg_n", 32'(seg_n), 32'(mon_ex.s));
            chk("dp_n", 32'(dp_n), 32'(mon_ex.dp));
            chk("frame_done", 32'(frame_done), 32'(mon_ex.fd));
            chk("busy", 32'(busy), 32'(mon_ex.busy));
        end
    end

    initial begin
        logic [31:0] rd;
        model_reset();
        reset_pulse(1'b1);
        reset_pulse(1'b0);

        // Free-running scan after reset release
        idle(70);

        // Update mid-frame, applied at the next boundary
        wait_slot(3, -1);
        cyc(1'b1, 1'b1, 32'h89AB_CDEF, 8'h00, 8'h00);
        idle(50);

        // Update in the wrap cycle goes straight to the active buffer
        wait_slot(ND - 1, DIV - 1);
        cyc(1'b1, 1'b1, 32'h0000_0005, 8'h00, 8'h00);
        idle(40);

        // Freeze for 10 clocks mid-slot, then resume
        wait_slot(5, 1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        idle(40);

        // Asynchronous reset mid-frame with an update pending
        wait_slot(2, -1);
        cyc(1'b1, 1'b1, 32'h1234_5678, 8'hFF, 8'h00);
        idle(3);
        reset_pulse(1'b1);
        idle(40);

        // Decimal point and blank mask
        cyc(1'b1, 1'b1, 32'hF000_0000, 8'h01, 8'h80);
        idle(70);

        // Leading zero patterns
        cyc(1'b1, 1'b1, 32'h0000_0120, 8'h00, 8'h00);
        idle(70);
        cyc(1'b1, 1'b1, 32'h0000_0000, 8'h00, 8'h00);
        idle(70);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_pulse(1'b1);
            end else begin
                rd = '0;
                for (int k = 0; k < 8; k++) begin
                    if ($urandom_range(0, 1) == 1) rd[4*k +: 4] = 4'($urandom_range(0, 15));
                end
                cyc($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, rd,
                    8'($urandom), 8'($urandom) & 8'($urandom));
            end
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
